// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  // Entries wider than this would be truncated by even_par.
  localparam int PAR_MAX_W  = 256;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port with write-to-read forwarding and parity check.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 4,
  parameter bit PAR_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wpar,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_par,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              perr
);

  logic              hit;
  logic [DATA_W-1:0] sel_data;
  logic              sel_par;
  logic              sel_err;

  // A write landing on the same address this cycle supplies the new data.
  assign hit      = wr_fire && (waddr == raddr);
  assign sel_data = hit ? wdata : arr_data;
  assign sel_par  = hit ? wpar  : arr_par;
  assign sel_err  = PAR_EN && (even_par(PAR_MAX_W'(sel_data)) != sel_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      perr   <= 1'b0;
    end else begin
      rvalid <= en && re;
      perr   <= en && re && sel_err;
      if (en && re) begin
        rdata <= sel_data;
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w_sync.sv
// DEPTH x DATA_W register file, 1 write / 2 registered read ports, clear sequencer.
// Optional per-entry even parity when REGFILE_PARITY_EN is defined.
//
// state    | meaning
// ST_CLEAR | writing INIT_VAL to entry clr_ptr each cycle; ports ignored
// ST_READY | normal operation; clr restarts the clear from entry 0
module regfile_2r1w_sync
  import regfile_pkg::*;
#(
  parameter  int                DATA_W   = DEF_DATA_W,
  parameter  int                DEPTH    = DEF_DEPTH,
  parameter  logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int                ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              perr_inj,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic              perr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid2,
  output logic              perr2
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_data;
  logic              wr_fire;
  logic              wpar;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              rd_par1, rd_par2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    arr_we    = 1'b0;
    arr_addr  = waddr;
    arr_data  = wdata;
    case (state_q)
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_addr  = clr_ptr_q;
        arr_data  = INIT_VAL;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // Clear wins over a simultaneous write.
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end else if (we) begin
          arr_we = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign ready   = (state_q == ST_READY);
  assign wr_fire = ready && we && !clr;

`ifdef REGFILE_PARITY_EN
  localparam bit PAR_EN = 1'b1;

  logic [DATA_W:0] mem [DEPTH];
  logic            arr_par;

  assign wpar    = even_par(PAR_MAX_W'(wdata)) ^ perr_inj;
  assign arr_par = ready ? wpar : even_par(PAR_MAX_W'(INIT_VAL));

  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem[arr_addr] <= {arr_par, arr_data};
    end
  end

  assign rd_data1 = mem[raddr1][DATA_W-1:0];
  assign rd_par1  = mem[raddr1][DATA_W];
  assign rd_data2 = mem[raddr2][DATA_W-1:0];
  assign rd_par2  = mem[raddr2][DATA_W];
`else
  localparam bit PAR_EN = 1'b0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              unused_perr_inj;

  assign unused_perr_inj = perr_inj;
  assign wpar            = 1'b0;

  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem[arr_addr] <= arr_data;
    end
  end

  assign rd_data1 = mem[raddr1];
  assign rd_par1  = 1'b0;
  assign rd_data2 = mem[raddr2];
  assign rd_par2  = 1'b0;
`endif

  regfile_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .PAR_EN(PAR_EN)
  ) u_rd1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ready),
    .re      (re1),
    .raddr   (raddr1),
    .wr_fire (wr_fire),
    .waddr   (waddr),
    .wdata   (wdata),
    .wpar    (wpar),
    .arr_data(rd_data1),
    .arr_par (rd_par1),
    .rdata   (rdata1),
    .rvalid  (rvalid1),
    .perr    (perr1)
  );

  regfile_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .PAR_EN(PAR_EN)
  ) u_rd2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ready),
    .re      (re2),
    .raddr   (raddr2),
    .wr_fire (wr_fire),
    .waddr   (waddr),
    .wdata   (wdata),
    .wpar    (wpar),
    .arr_data(rd_data2),
    .arr_par (rd_par2),
    .rdata   (rdata2),
    .rvalid  (rvalid2),
    .perr    (perr2)
  );

endmodule
